// File: rtl/fifo_burst_rd.sv
// Burst read controller for a first-word-fall-through FIFO: waits for a full burst (or FLUSH), then streams it out.
// Optional pop-sequence checker enabled by defining FIFO_BURST_RD_SEQCHK_EN.
module fifo_burst_rd #(
  parameter int unsigned DWID = 32,
  parameter int unsigned AWID = 10,
  parameter int unsigned BLEN = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  output logic            RDENA,
  input  logic [DWID-1:0] RDDAT,
  input  logic [AWID-1:0] RDLEV,
  input  logic            FLUSH,
  output logic            OVALID,
  input  logic            ORDY,
  output logic [DWID-1:0] ODAT,
  output logic            OLAST,
  output logic            BUSY,
  output logic            ERR
);

  localparam logic [AWID-1:0] BLEN_L = AWID'(BLEN);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AWID-1:0] rem, rem_nxt;
  logic            accept;

  assign accept = OVALID && ORDY;
  assign BUSY   = (state == XFER);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    RDENA     = 1'b0;
    case (state)
      IDLE: begin
        // Full burst wins over a flush request.
        if (RDLEV >= BLEN_L) begin
          state_nxt = XFER;
          rem_nxt   = BLEN_L;
        end else if (FLUSH && (RDLEV != '0)) begin
          state_nxt = XFER;
          rem_nxt   = RDLEV;
        end
      end
      XFER: begin
        RDENA = (rem != '0) && (RDLEV != '0) && (!OVALID || ORDY);
        if (RDENA) rem_nxt = rem - 1'b1;
        if (accept && OLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Output register: a pop refills it directly, so accept+pop leaves no bubble.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OVALID <= 1'b0;
      OLAST  <= 1'b0;
      ODAT   <= '0;
    end else if (RDENA) begin
      OVALID <= 1'b1;
      OLAST  <= (rem == AWID'(1));
      ODAT   <= RDDAT;
    end else if (accept) begin
      OVALID <= 1'b0;
      OLAST  <= 1'b0;
    end
  end

`ifdef FIFO_BURST_RD_SEQCHK_EN
  logic [DWID-1:0] exp_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      exp_cnt <= '0;
      ERR     <= 1'b0;
    end else if (RDENA) begin
      exp_cnt <= exp_cnt + 1'b1;
      if (RDDAT != exp_cnt) ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule
